// File: rtl/pack_str_framer_if.sv
// Element type and handshake bundle for the pack_str_framer.
package pack_str_pkg;
    typedef struct packed {
        logic a;
        logic b;
    } pack_str_t;
endpackage

interface pack_str_framer_if #(
    parameter int unsigned NUM_ELEM = 3
);
    import pack_str_pkg::*;

    localparam int unsigned LEN_W = $clog2(NUM_ELEM + 1);

    logic                in_valid;
    logic                in_ready;
    pack_str_t           in_elem;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    pack_str_t           out_elems [NUM_ELEM];
    logic [NUM_ELEM-1:0] out_a;
    logic                out_b [NUM_ELEM];
    logic [LEN_W-1:0]    out_len;

    // Framer side
    modport slave (
        input  in_valid, in_elem, flush, out_ready,
        output in_ready, out_valid, out_elems, out_a, out_b, out_len
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_elem, flush, out_ready,
        input  in_ready, out_valid, out_elems, out_a, out_b, out_len
    );
endinterface

// File: rtl/pack_str_framer.sv
// Collects 2-bit elements into frames of NUM_ELEM and presents them with a
// one-frame pending buffer so input can run ahead of a stalled consumer.
module pack_str_framer
    import pack_str_pkg::*;
#(
    parameter int unsigned NUM_ELEM = 3
) (
    input  logic             clk,
    input  logic             rst,
    pack_str_framer_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(NUM_ELEM + 1);
    localparam int unsigned IDX_W = $clog2(NUM_ELEM);

    typedef enum logic {
        S_FILL,
        S_PEND
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    pack_str_t        fill_q [NUM_ELEM];
    pack_str_t        fill_d [NUM_ELEM];
    pack_str_t        out_elems_q [NUM_ELEM];
    pack_str_t        out_elems_d [NUM_ELEM];
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic [LEN_W-1:0] pend_len_q, pend_len_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_c;
    logic             accept_c;
    logic             xfer_c;
    logic             slot_free_c;
    logic             complete_c;
    logic [LEN_W-1:0] frame_len_c;
    pack_str_t        frame_c [NUM_ELEM];

    // Drive the bus: registered frame plus combinational field slices
    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.out_valid = out_valid_q;
        bus.out_len   = out_len_q;
        for (int k = 0; k < int'(NUM_ELEM); k++) begin
            bus.out_elems[k] = out_elems_q[k];
            bus.out_a[k]     = out_elems_q[k].a;
            bus.out_b[k]     = out_elems_q[k].b;
        end
    end

    // Next-state, fill and output-slot logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        out_elems_d = out_elems_q;
        out_len_d   = out_len_q;
        pend_len_d  = pend_len_q;
        out_valid_d = out_valid_q;

        in_ready_c  = (state_q == S_FILL) && !rst;
        accept_c    = bus.in_valid && in_ready_c;
        xfer_c      = out_valid_q && bus.out_ready;
        slot_free_c = !out_valid_q || bus.out_ready;

        if (accept_c) begin
            fill_d[idx_q] = bus.in_elem;
        end

        complete_c  = (state_q == S_FILL) &&
                      ((accept_c && (idx_q == IDX_W'(NUM_ELEM - 1))) ||
                       (bus.flush && ((idx_q != '0) || accept_c)));
        frame_len_c = LEN_W'(idx_q) + LEN_W'(accept_c);

        // Unused tail slots of a short frame read as zero
        for (int k = 0; k < int'(NUM_ELEM); k++) begin
            frame_c[k] = (LEN_W'(k) < frame_len_c) ? fill_d[k] : pack_str_t'(2'b00);
        end

        case (state_q)
            S_FILL: begin
                if (accept_c) begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (complete_c) begin
                    idx_d = '0;
                    if (slot_free_c) begin
                        out_elems_d = frame_c;
                        out_len_d   = frame_len_c;
                        out_valid_d = 1'b1;
                    end else begin
                        fill_d     = frame_c;
                        pend_len_d = frame_len_c;
                        state_d    = S_PEND;
                    end
                end else if (xfer_c) begin
                    out_valid_d = 1'b0;
                end
            end
            S_PEND: begin
                if (xfer_c) begin
                    out_elems_d = fill_q;
                    out_len_d   = pend_len_q;
                    out_valid_d = 1'b1;
                    state_d     = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            idx_q       <= '0;
            out_len_q   <= '0;
            pend_len_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < int'(NUM_ELEM); k++) begin
                fill_q[k]      <= '0;
                out_elems_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_len_q   <= out_len_d;
            pend_len_q  <= pend_len_d;
            out_valid_q <= out_valid_d;
            fill_q      <= fill_d;
            out_elems_q <= out_elems_d;
        end
    end

endmodule

// File: doc/pack_str_framer.md
Name: pack_str_framer

Overview:
- Upstream stage for the packed-struct array consumer.
- Collects a serial stream of 2-bit `pack_str_t` elements (`{a,b}`, `a` = MSB) into frames of NUM_ELEM elements.
- Presents each frame three ways:
  - as an unpacked array of structs;
  - as a packed vector of the `a` fields;
  - as an unpacked array of the `b` fields.
- Valid/ready handshake on both sides, with one pending-frame buffer so input can run ahead of a stalled consumer.

Parameters:
- NUM_ELEM, 3, elements per full frame; legal range ≥ 2.
- LEN_W, $clog2(NUM_ELEM+1), width of `out_len`; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  `in_elem` valid.
- in_ready  output  1  block can accept `in_elem`.
- in_elem  input  pack_str_t (2)  element data.
- flush  input  1  close the current partial frame.
- out_valid  output  1  frame on `out_*` valid.
- out_ready  input  1  consumer accepts frame.
- out_elems  output  pack_str_t [NUM_ELEM] (unpacked)  frame elements; index 0 = first accepted.
- out_a  output  [NUM_ELEM-1:0] packed  bit k = out_elems[k].a.
- out_b  output  logic [NUM_ELEM] (unpacked)  out_b[k] = out_elems[k].b.
- out_len  output  LEN_W  number of valid elements, 1..NUM_ELEM.

Behaviour:
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - out_* is held stable while out_valid && !out_ready.
- Storage:
  - Fill buffer fill_q[NUM_ELEM] plus index idx (0..NUM_ELEM-1).
  - Output register set (out_elems, out_len, out_valid).
- FSM state FILL (collecting):
  - An accept writes fill_q[idx] and increments idx.
  - Frame completes on an accept at idx == NUM_ELEM-1, or when flush is high and (idx > 0 or accept this cycle).
  - On completion: len = idx+1 if accepted this cycle, else idx.
  - Slots ≥ len are forced to 2'b00 in the frame.
- Frame hand-off on completion:
  - If the output slot is free (!out_valid or out_ready): the frame loads into the output registers at the same edge and out_valid=1 next cycle. Latency is 1 cycle from the final accept to out_valid. idx returns to 0; stay in FILL.
  - Otherwise: go to PEND with the frame held in fill_q; idx returns to 0.
- flush with idx == 0 and no accept: ignored; no zero-length frames.
- State PEND:
  - in_ready = 0; flush ignored.
  - On an output transfer, the pending frame loads into the output registers at that same edge. out_valid stays 1 with no bubble. Return to FILL; in_ready = 1 next cycle.
- in_ready = 1 in FILL, 0 in PEND, 0 while rst is high.
- Output slot with no new frame loading: an output transfer clears out_valid next cycle.
- Throughput: with out_ready held high, one frame per NUM_ELEM accepts and no input stalls.
- Reset (any time, including mid-frame or mid-stall):
  - idx = 0, state = FILL, out_valid = 0, out_elems all 2'b00, out_len = 0.
  - Partial and pending frames are discarded.
  - in_ready = 1 on the first cycle after rst deasserts.
- out_a and out_b are combinational slices of the out_elems registers and carry no extra latency.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, in_ready=0 during reset, out_len=0; in_ready=1 the cycle after release.
- Full frame, NUM_ELEM=3, out_ready=1: accept 01,10,11 on consecutive cycles → the next cycle shows:
  - out_valid=1, out_elems={[0]=01,[1]=10,[2]=11};
  - out_a=3'b110, out_b[0]=1, out_b[1]=0, out_b[2]=1, out_len=3;
  - out_valid=0 the cycle after.
- Backpressure, out_ready=0:
  - Send 6 elements → frame 1 (00,01,10) on output; frame 2 (11,11,01) pending; in_ready=0 after the 6th accept; the 7th element stalls.
  - Pulse out_ready for 1 cycle → frame 2 on output the next cycle with out_valid never dropping; in_ready=1.
- Flush with accept: at idx 0, in_elem=11 with flush=1 → next cycle out_len=1, out_elems[0]=11, [1]=[2]=00, out_a=3'b001.
- Flush boundaries:
  - flush with an empty buffer → no frame.
  - 2 accepts (10,01) then flush alone → out_len=2, out_a=3'b001, out_b[1]=1.
- Reset mid-operation: accept 2 elements, assert rst, then accept 01,01,01 → single frame, all elements 01, out_len=3, no stale data.
